// File: rtl/palette_lookup_pkg.sv
// Shared types and default sizes for the palette lookup path.
package palette_lookup_pkg;

   localparam int DEF_ITER_BITS = 10;
   localparam int DEF_ADDR_BITS = 19;   // 640x480 framestore
   localparam int DEF_DEPTH     = 1024;

   typedef logic [15:0] rgb565_t;

   typedef enum logic [1:0] {
      EMPTY,
      LOADING,
      READY
   } pal_state_t;

endpackage

// File: rtl/palette_lookup_if.sv
// Pixel-in / colour-out handshake bundle; master is the pixel source and framestore side.
interface palette_lookup_if
   import palette_lookup_pkg::*;
#(
   parameter int ITER_BITS = DEF_ITER_BITS,
   parameter int ADDR_BITS = DEF_ADDR_BITS
);
   logic                 pix_valid;
   logic                 pix_ready;
   logic [ITER_BITS-1:0] pix_iter;
   logic [ADDR_BITS-1:0] pix_addr;
   logic                 col_valid;
   logic                 col_ready;
   rgb565_t              col_value;
   logic [ADDR_BITS-1:0] col_addr;

   modport master (
      output pix_valid, pix_iter, pix_addr, col_ready,
      input  pix_ready, col_valid, col_value, col_addr
   );

   modport slave (
      input  pix_valid, pix_iter, pix_addr, col_ready,
      output pix_ready, col_valid, col_value, col_addr
   );
endinterface

// File: rtl/palette_ram.sv
// Palette storage: one write port, one synchronous read-first read port with enable.
module palette_ram
   import palette_lookup_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int AW    = DEF_ITER_BITS
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  rgb565_t       wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output rgb565_t       rdata
);
   rgb565_t mem [DEPTH];

   // Out-of-range indices are dropped on write and read back as zero.
   always_ff @(posedge clk) begin
      if (we && (int'(waddr) < DEPTH))
         mem[waddr] <= wdata;
      if (re)
         rdata <= (int'(raddr) < DEPTH) ? mem[raddr] : '0;
   end
endmodule

// File: rtl/palette_lookup.sv
// Maps escape iteration counts to RGB565 through a loadable palette, two-stage stallable pipe.
module palette_lookup
   import palette_lookup_pkg::*;
#(
   parameter int ITER_BITS = DEF_ITER_BITS,
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int DEPTH     = DEF_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_active,
   input  logic [ITER_BITS-1:0] load_index,
   input  rgb565_t              load_colour,
   input  logic                 load_done,
   input  logic [ITER_BITS-1:0] max_iterations,
   input  rgb565_t              inside_colour,
   output logic                 palette_ready,
   palette_lookup_if.slave      bus
);
   pal_state_t state, state_n;
   logic       load_q;

   logic                 s0_valid, s0_inside;
   logic [ITER_BITS-1:0] s0_raddr;
   logic [ADDR_BITS-1:0] s0_addr;
   logic                 s1_valid, s1_inside;
   logic [ADDR_BITS-1:0] s1_addr;
   rgb565_t              ram_q;
   logic                 s1_free, s0_adv, accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= EMPTY;
         palette_ready <= 1'b0;
         load_q        <= 1'b0;
      end else begin
         state         <= state_n;
         palette_ready <= (state_n == READY);
         load_q        <= load_active;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         EMPTY:   if (load_active) state_n = LOADING;
         LOADING: if (load_done)   state_n = READY;
         READY:   if (load_active) state_n = LOADING;
         default: state_n = EMPTY;
      endcase
   end

   // Stage 0 and stage 1 form the two-entry buffer: a stalled output freezes
   // both, and the RAM read is gated so ram_q holds with stage 1.
   assign s1_free       = !s1_valid || bus.col_ready;
   assign s0_adv        = s0_valid && s1_free;
   assign bus.pix_ready = palette_ready && (!s0_valid || s1_free);
   assign accept        = bus.pix_valid && bus.pix_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_valid  <= 1'b0;
         s0_inside <= 1'b0;
         s0_raddr  <= '0;
         s0_addr   <= '0;
         s1_valid  <= 1'b0;
         s1_inside <= 1'b0;
         s1_addr   <= '0;
      end else begin
         if (accept) begin
            s0_valid  <= 1'b1;
            s0_inside <= (bus.pix_iter >= max_iterations);
            s0_raddr  <= bus.pix_iter;
            s0_addr   <= bus.pix_addr;
         end else if (s0_adv) begin
            s0_valid <= 1'b0;
         end
         if (s0_adv) begin
            s1_valid  <= 1'b1;
            s1_inside <= s0_inside;
            s1_addr   <= s0_addr;
         end else if (bus.col_ready) begin
            s1_valid <= 1'b0;
         end
      end
   end

   palette_ram #(
      .DEPTH (DEPTH),
      .AW    (ITER_BITS)
   ) u_ram (
      .clk   (clk),
      .we    (load_q),
      .waddr (load_index),
      .wdata (load_colour),
      .re    (s0_adv),
      .raddr (s0_raddr),
      .rdata (ram_q)
   );

   assign bus.col_valid = s1_valid;
   assign bus.col_addr  = s1_addr;
   assign bus.col_value = s1_valid ? (s1_inside ? inside_colour : ram_q) : '0;
endmodule

// File: tb/tb_palette_lookup.sv
// Directed plus randomized checks of palette_lookup against a palette-array/queue model.
module tb_palette_lookup;
   localparam int DEPTH = 1023;

   typedef struct {
      logic [15:0] val;
      logic [18:0] addr;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        load_active;
   logic [9:0]  load_index;
   logic [15:0] load_colour;
   logic        load_done;
   logic [9:0]  max_iterations;
   logic [15:0] inside_colour;
   logic        palette_ready;

   palette_lookup_if #(.ITER_BITS(10), .ADDR_BITS(19)) bus ();

   palette_lookup #(
      .ITER_BITS (10),
      .ADDR_BITS (19),
      .DEPTH     (DEPTH)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .load_active    (load_active),
      .load_index     (load_index),
      .load_colour    (load_colour),
      .load_done      (load_done),
      .max_iterations (max_iterations),
      .inside_colour  (inside_colour),
      .palette_ready  (palette_ready),
      .bus            (bus)
   );

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          lat_chk = 0;
   logic [15:0] model_pal [1024];
   exp_t        expq [$];
   int          tx_iter [$];
   logic [18:0] next_addr = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: expected colour is fixed at accept time from the palette model.
   initial begin : monitor
      exp_t        e;
      bit          pv;
      logic        pr;
      logic [15:0] pval;
      logic [18:0] paddr;
      pv = 0; pr = 1'b0; pval = '0; paddr = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            expq.delete();
            pv = 0;
         end else begin
            if (pv && !pr) begin
               chk("hold_valid", 32'(bus.col_valid), 32'd1);
               chk("hold_value", 32'(bus.col_value), 32'(pval));
               chk("hold_addr",  32'(bus.col_addr),  32'(paddr));
            end
            if (bus.col_valid && bus.col_ready) begin
               if (expq.size() == 0) begin
                  chk("extra_pixel", 32'(bus.col_addr), 32'hFFFF_FFFF);
               end else begin
                  e = expq.pop_front();
                  chk("col_value", 32'(bus.col_value), 32'(e.val));
                  chk("col_addr",  32'(bus.col_addr),  32'(e.addr));
                  if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd2);
               end
            end
            if (bus.pix_valid && bus.pix_ready) begin
               e.val  = (bus.pix_iter >= max_iterations) ? inside_colour : model_pal[bus.pix_iter];
               e.addr = bus.pix_addr;
               e.cyc  = cyc;
               expq.push_back(e);
            end
            pv    = bus.col_valid;
            pr    = bus.col_ready;
            pval  = bus.col_value;
            paddr = bus.col_addr;
         end
      end
   end

   function automatic int pick_iter();
      int m;
      m = int'(max_iterations);
      case ($urandom_range(0, 7))
         0:       return 0;
         1:       return (m > 0) ? m - 1 : 0;
         2:       return m;
         3:       return 1023;
         default: return int'($urandom_range(0, 1023));
      endcase
   endfunction

   task automatic load_palette(input int n, input int rot, input bit seq_vals, input bit started);
      int          idx;
      logic [15:0] v;
      bus.col_ready = 1'b1;
      if (!started) begin
         load_active = 1'b1;
         tick();
      end
      for (int i = 0; i < n; i++) begin
         idx = (i + rot) % n;
         v   = seq_vals ? 16'(idx) : 16'($urandom);
         load_index  = 10'(idx);
         load_colour = v;
         if (idx < DEPTH) model_pal[idx] = v;
         load_active = (i < n - 1);
         load_done   = (i == n - 1);
         chk("ready_during_load", 32'(palette_ready), 32'd0);
         chk("pix_ready_during_load", 32'(bus.pix_ready), 32'd0);
         tick();
      end
      load_done = 1'b0;
      chk("ready_after_done", 32'(palette_ready), 32'd1);
      chk("pix_ready_after_done", 32'(bus.pix_ready), 32'd1);
   endtask

   task automatic drain();
      int g;
      g = 0;
      bus.pix_valid = 1'b0;
      bus.col_ready = 1'b1;
      while ((expq.size() != 0 || bus.col_valid) && g < 50) begin
         tick();
         g++;
      end
      chk("drain_queue", 32'(expq.size()), 32'd0);
      chk("drain_col_valid", 32'(bus.col_valid), 32'd0);
   endtask

   // mode 0: col_ready high, 1: col_ready 1010..., 2: random valid/ready
   task automatic run_stream(input int mode);
      int g;
      bit acc;
      g = 0;
      lat_chk = (mode == 0);
      while (tx_iter.size() > 0 && g < 20000) begin
         bus.pix_iter  = 10'(tx_iter[0]);
         bus.pix_addr  = next_addr;
         bus.pix_valid = (mode != 2) || ($urandom_range(0, 3) != 0);
         bus.col_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 0) : 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = bus.pix_valid && bus.pix_ready;
         if (acc) begin
            void'(tx_iter.pop_front());
            next_addr++;
         end
         tick();
         g++;
      end
      chk("stream_all_sent", 32'(tx_iter.size()), 32'd0);
      drain();
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) tx_iter.push_back(pick_iter());
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) model_pal[i] = '0;
      reset          = 1'b1;
      load_active    = 1'b0;
      load_index     = '0;
      load_colour    = '0;
      load_done      = 1'b0;
      max_iterations = 10'd1023;
      inside_colour  = 16'hF81F;
      bus.pix_valid  = 1'b0;
      bus.pix_iter   = '0;
      bus.pix_addr   = '0;
      bus.col_ready  = 1'b1;
      repeat (3) tick();
      chk("rst_palette_ready", 32'(palette_ready), 32'd0);
      chk("rst_pix_ready",     32'(bus.pix_ready), 32'd0);
      chk("rst_col_valid",     32'(bus.col_valid), 32'd0);
      chk("rst_col_value",     32'(bus.col_value), 32'd0);
      chk("rst_col_addr",      32'(bus.col_addr),  32'd0);
      reset = 1'b0;
      tick();

      // Identity palette, then the directed lookups including the last entry.
      load_palette(1023, 0, 1'b1, 1'b0);
      tx_iter = '{5, 1023, 0, 1022};
      run_stream(0);

      fill(40);
      run_stream(1);

      // 1024 writes into a 1023-deep palette: the final index must be dropped.
      load_palette(1024, 0, 1'b0, 1'b0);
      fill(200);
      run_stream(2);
      fill(60);
      run_stream(0);

      // Reload begins with two pixels in flight; they keep the old colours.
      lat_chk       = 1'b1;
      bus.col_ready = 1'b1;
      bus.pix_valid = 1'b1;
      bus.pix_iter  = 10'd10;
      bus.pix_addr  = next_addr;
      chk("ld_pix_ready_a", 32'(bus.pix_ready), 32'd1);
      tick();
      next_addr++;
      bus.pix_iter = 10'd20;
      bus.pix_addr = next_addr;
      load_active  = 1'b1;
      chk("ld_pix_ready_b", 32'(bus.pix_ready), 32'd1);
      tick();
      next_addr++;
      bus.pix_valid = 1'b0;
      chk("ld_pix_ready_drop", 32'(bus.pix_ready), 32'd0);
      load_palette(1024, 20, 1'b0, 1'b1);
      drain();
      fill(80);
      run_stream(2);

      // Reset with a stalled pipe and a partial load in progress.
      lat_chk       = 1'b0;
      bus.col_ready = 1'b0;
      bus.pix_valid = 1'b1;
      bus.pix_iter  = 10'd7;
      bus.pix_addr  = next_addr;
      repeat (4) tick();
      load_active = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("mid_rst_palette_ready", 32'(palette_ready), 32'd0);
      chk("mid_rst_pix_ready",     32'(bus.pix_ready), 32'd0);
      chk("mid_rst_col_valid",     32'(bus.col_valid), 32'd0);
      chk("mid_rst_col_value",     32'(bus.col_value), 32'd0);
      chk("mid_rst_col_addr",      32'(bus.col_addr),  32'd0);
      reset         = 1'b0;
      load_active   = 1'b0;
      bus.col_ready = 1'b1;
      repeat (5) begin
         tick();
         chk("post_rst_pix_ready", 32'(bus.pix_ready), 32'd0);
         chk("post_rst_col_valid", 32'(bus.col_valid), 32'd0);
      end
      bus.pix_valid  = 1'b0;
      max_iterations = 10'($urandom_range(1, 1023));
      load_palette(1024, 0, 1'b0, 1'b0);
      fill(200);
      run_stream(2);
      fill(50);
      run_stream(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
